bitserial_alu_ctrl: RTL and testbench

//  Sequencer that reuses one 1-bit ALU slice (full adder + mux4x1 op select) to run a WIDTH-bit op, LSB first.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu1_slice.sv | 40 ++++
 rtl/bitserial_alu_ctrl.sv | 138 +++++++++++++
 tb/tb_bitserial_alu_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared op and state encodings for the bit-serial ALU
//               controller and its 1-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Op select; also drives the slice output mux directly.
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ADD and SUB both use the adder path and the carry flop.
  function automatic logic op_is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu1_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu1_slice
// Description : One-bit ALU slice: full adder plus a 4:1 output mux
//               selecting AND / OR / SUM / SUM.
// Revision    : 1.0 - initial release
// ============================================================================
module alu1_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] sel,
  output logic       y,
  output logic       cout
);

  logic w_sum;

  // Full adder; the caller pre-inverts b for subtraction.
  always_comb begin
    w_sum = a ^ b ^ cin;
    cout  = (a & b) | (a & cin) | (b & cin);
  end

  // Output mux: both arithmetic encodings select the adder sum.
  always_comb begin
    y = 1'b0;
    case (sel)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = w_sum;
      OP_SUB:  y = w_sum;
      default: y = 1'b0;
    endcase
  end

endmodule : alu1_slice
`default_nettype wire

// File: rtl/bitserial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bitserial_alu_ctrl
// Description : Sequencer running a WIDTH-bit AND/OR/ADD/SUB through a single
//               1-bit slice, LSB first, one bit per clock, with valid/ready
//               handshakes on operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module bitserial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Holds the upper WIDTH-1 bits of the result being assembled; the final
  // bit comes straight from the slice on the last RUN cycle.
  logic [WIDTH-2:0] r_res_sr;
  logic [1:0]       r_op;
  logic             r_carry;

  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_is_sub;
  logic             w_is_arith;
  logic             w_y;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_full;

  assign w_accept   = (r_state == ST_IDLE) && in_valid;
  assign w_run      = (r_state == ST_RUN);
  assign w_last     = w_run && (r_cnt == C_LAST);
  assign w_is_sub   = (r_op == OP_SUB);
  assign w_is_arith = op_is_arith(r_op);
  assign w_res_full = {w_y, r_res_sr};

  alu1_slice u_slice (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0] ^ w_is_sub),
    .cin  (r_carry),
    .sel  (r_op),
    .y    (w_y),
    .cout (w_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_RUN;
      end
      ST_RUN: begin
        if (r_cnt == C_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand/result shift registers, bit counter and carry flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_op     <= OP_AND;
      r_carry  <= 1'b0;
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_op     <= op;
      // Carry-in of 1 supplies the +1 of A + ~B + 1.
      r_carry  <= (op == OP_SUB);
    end else if (w_run) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_res_sr <= w_res_full[WIDTH-1:1];
      if (w_is_arith) r_carry <= w_cout;
      // Counter holds at the last index instead of wrapping.
      if (!w_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result and flags, captured once as the MSB leaves the slice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (w_last) begin
      result    <= w_res_full;
      carry_out <= w_is_arith & w_cout;
      // r_carry is the carry into the MSB on this cycle.
      overflow  <= w_is_arith & (r_carry ^ w_cout);
      zero      <= (w_res_full == '0);
    end
  end

endmodule : bitserial_alu_ctrl
`default_nettype wire

// File: tb/tb_bitserial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitserial_alu_ctrl
// Description : Self-checking bench for bitserial_alu_ctrl (WIDTH=32):
//               directed cases plus randomized ops against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitserial_alu_ctrl;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  int n_cmp;
  int n_bad;

  bitserial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain WIDTH+1-bit arithmetic and sign rules.
  task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic [1:0] o, output logic [WIDTH-1:0] r,
                       output logic c, output logic v, output logic z);
    logic [WIDTH:0] s;
    c = 1'b0;
    v = 1'b0;
    case (o)
      2'b00: r = x & y;
      2'b01: r = x | y;
      2'b10: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      default: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        v = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
    endcase
    z = (r == '0);
  endtask

  // One full transaction. noise: scramble inputs during RUN.
  // hold: DONE cycles with out_ready=0 and in_valid=1. abort_at: cnt at
  // which rst is pulsed (-1 = never).
  task automatic run_op(input string tag, input logic [WIDTH-1:0] ta,
                        input logic [WIDTH-1:0] tb, input logic [1:0] top,
                        input bit noise, input int hold, input int abort_at);
    logic [WIDTH-1:0] er;
    logic ec, ev, ez;
    int n;
    int k;
    model(ta, tb, top, er, ec, ev, ez);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
      return;
    end
    a = ta; b = tb; op = top; in_valid = 1'b1;
    @(posedge clk);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (abort_at == k) begin
        rst = 1'b1;
        #1;
        check({tag, "_abort_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_abort_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_abort_result"},    64'(result),    64'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        return;
      end
      if (noise && k < WIDTH - 2) begin
        in_valid = 1'($urandom);
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) break;
      @(posedge clk);
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(WIDTH));
    check({tag, "_result"},  64'(result),    64'(er));
    check({tag, "_carry"},   64'(carry_out), 64'(ec));
    check({tag, "_ovf"},     64'(overflow),  64'(ev));
    check({tag, "_zero"},    64'(zero),      64'(ez));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom; op = 2'($urandom);
      @(negedge clk);
      check({tag, "_bp_valid"},  64'(out_valid), 64'd1);
      check({tag, "_bp_ready"},  64'(in_ready),  64'd0);
      check({tag, "_bp_result"}, 64'(result),    64'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check({tag, "_done_in_ready"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post_valid"},  64'(out_valid), 64'd0);
    check({tag, "_post_ready"},  64'(in_ready),  64'd1);
    check({tag, "_post_result"}, 64'(result),    64'(er));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; op = 2'b00;
    rst = 1'b1;
    #1;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_flags",     64'({carry_out, overflow, zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, 2'b10, 1'b0, 0, -1);
    run_op("sub_ovf",   32'h80000000, 32'h00000001, 2'b11, 1'b0, 0, -1);
    run_op("and",       32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 1'b0, 0, -1);
    run_op("or",        32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 1'b0, 0, -1);
    run_op("backpress", 32'h12345678, 32'h11111111, 2'b10, 1'b0, 5, -1);
    run_op("after_bp",  32'h00000007, 32'h00000009, 2'b10, 1'b0, 0, -1);
    run_op("sub_noise", 32'h00000003, 32'h00000005, 2'b11, 1'b1, 0, -1);
    run_op("abort",     32'h0000FFFF, 32'h00000001, 2'b10, 1'b0, 0, 10);
    run_op("add_5_3",   32'h00000005, 32'h00000003, 2'b10, 1'b0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'hFFFFFFFF;
        2: rb = ra;
        3: ra = 32'h7FFFFFFF;
        default: ;
      endcase
      run_op("rand", ra, rb, 2'($urandom), 1'($urandom), int'($urandom_range(0, 3)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bitserial_alu_ctrl
`default_nettype wire
